execute_unit: RTL and testbench

Execute stage of the 16-bit datapath, directly downstream of the register file. It takes the two operands the register file reads out, plus the opcode and destination from decode. It produces a registered result together with `write_reg`/`regWrite`, which feed the register file write port, and a 4-bit NZCV flag register. Most operations take one cycle; MUL is a 16-iteration shift-add sequence behind a start/busy/done handshake.

---
 rtl/execute_pkg.sv | 41 ++++
 rtl/execute_mul_shift_add.sv | 61 ++++++
 rtl/execute_unit.sv | 154 +++++++++++++++
 tb/tb_execute_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared constants and flag helpers for the execute stage.
package execute_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MUL  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Signed overflow from operand and result sign bits.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  // N and Z from a new result, C and V carried over from the old flags.
  function automatic logic [3:0] nz_update(input logic neg, input logic zero,
                                           input logic [3:0] old);
    logic [3:0] f;
    f = old;
    f[FLAG_N] = neg;
    f[FLAG_Z] = zero;
    return f;
  endfunction

endpackage

// File: rtl/execute_mul_shift_add.sv
// Iterative shift-add multiplier: one step per cycle, WIDTH steps after load.
module mul_shift_add #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             last_step
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] count_r;
  logic             running_r;
  logic [WIDTH-1:0] acc_next_s;

  // Accumulator value after the step taken on the coming edge.
  always_comb begin
    acc_next_s = acc_r;
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // product is combinational so the owner can capture it on the final step edge.
  assign product   = acc_next_s;
  assign last_step = running_r && (count_r == LAST_CNT);

  // Operand load and per-cycle shift-add iteration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand_r   <= {WIDTH{1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      running_r <= 1'b0;
    end else if (load) begin
      mcand_r   <= a;
      mplier_r  <= b;
      acc_r     <= {WIDTH{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      running_r <= 1'b1;
    end else if (running_r) begin
      acc_r     <= acc_next_s;
      mcand_r   <= mcand_r << 1'b1;
      mplier_r  <= mplier_r >> 1'b1;
      count_r   <= count_r + 1'b1;
      running_r <= (count_r != LAST_CNT);
    end
  end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU ops, multi-cycle MUL, NZCV flags and writeback.
module execute_unit
  import execute_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] dest_reg,
  input  logic [WIDTH-1:0]      operand_a,
  input  logic [WIDTH-1:0]      operand_b,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic [ADDR_WIDTH-1:0] write_reg,
  output logic                  regWrite,
  output logic [3:0]            flags
);

  logic [1:0]            state_r;
  logic [1:0]            next_state_s;
  logic                  busy_r;
  logic                  done_r;
  logic                  reg_write_r;
  logic [WIDTH-1:0]      result_r;
  logic [ADDR_WIDTH-1:0] write_reg_r;
  logic [3:0]            flags_r;

  logic                  accept_s;
  logic                  mul_load_s;
  logic                  wb_en_s;
  logic [WIDTH:0]        wide_s;
  logic [WIDTH-1:0]      alu_result_s;
  logic [3:0]            alu_flags_s;
  logic [WIDTH-1:0]      product_s;
  logic                  last_step_s;

  assign accept_s   = (state_r == ST_IDLE) && start;
  assign mul_load_s = accept_s && (opcode == OP_MUL);

  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clock     (clock),
    .reset     (reset),
    .load      (mul_load_s),
    .a         (operand_a),
    .b         (operand_b),
    .product   (product_s),
    .last_step (last_step_s)
  );

  // Single-cycle ALU result and flags from the live operands.
  always_comb begin
    wide_s       = {(WIDTH+1){1'b0}};
    alu_result_s = {WIDTH{1'b0}};
    alu_flags_s  = flags_r;
    case (opcode)
      OP_ADD: begin
        wide_s       = {1'b0, operand_a} + {1'b0, operand_b};
        alu_result_s = wide_s[WIDTH-1:0];
        alu_flags_s[FLAG_C] = wide_s[WIDTH];
        alu_flags_s[FLAG_V] = add_ovf(operand_a[WIDTH-1], operand_b[WIDTH-1], wide_s[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        wide_s       = {1'b0, operand_a} - {1'b0, operand_b};
        alu_result_s = wide_s[WIDTH-1:0];
        alu_flags_s[FLAG_C] = ~wide_s[WIDTH];
        alu_flags_s[FLAG_V] = sub_ovf(operand_a[WIDTH-1], operand_b[WIDTH-1], wide_s[WIDTH-1]);
      end
      OP_AND: alu_result_s = operand_a & operand_b;
      OP_ORR: alu_result_s = operand_a | operand_b;
      OP_EOR: alu_result_s = operand_a ^ operand_b;
      OP_LSL: begin
        // Bit WIDTH of the widened shift is the last bit pushed out of the top.
        wide_s       = {1'b0, operand_a} << operand_b[3:0];
        alu_result_s = wide_s[WIDTH-1:0];
        if (operand_b[3:0] != 4'd0) begin
          alu_flags_s[FLAG_C] = wide_s[WIDTH];
        end else begin
          alu_flags_s[FLAG_C] = flags_r[FLAG_C];
        end
      end
      default: alu_result_s = {WIDTH{1'b0}};
    endcase
    alu_flags_s[FLAG_N] = alu_result_s[WIDTH-1];
    alu_flags_s[FLAG_Z] = (alu_result_s == {WIDTH{1'b0}});
  end

  // Next-state and writeback-enable decode.
  always_comb begin
    next_state_s = ST_IDLE;
    wb_en_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = (opcode == OP_MUL) ? ST_MUL : ST_DONE;
          wb_en_s      = (opcode != OP_CMP);
        end else begin
          next_state_s = ST_IDLE;
          wb_en_s      = 1'b0;
        end
      end
      ST_MUL: begin
        if (last_step_s) begin
          next_state_s = ST_DONE;
          wb_en_s      = 1'b1;
        end else begin
          next_state_s = ST_MUL;
          wb_en_s      = 1'b0;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, handshake, result, flag and writeback registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      reg_write_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      write_reg_r <= {ADDR_WIDTH{1'b0}};
      flags_r     <= 4'b0000;
    end else begin
      state_r     <= next_state_s;
      busy_r      <= (next_state_s != ST_IDLE);
      done_r      <= (next_state_s == ST_DONE);
      reg_write_r <= (next_state_s == ST_DONE) && wb_en_s;
      if (accept_s) begin
        write_reg_r <= dest_reg;
      end
      if (accept_s && (opcode != OP_MUL)) begin
        result_r <= alu_result_s;
        flags_r  <= alu_flags_s;
      end else if ((state_r == ST_MUL) && last_step_s) begin
        result_r <= product_s;
        flags_r  <= nz_update(product_s[WIDTH-1], product_s == {WIDTH{1'b0}}, flags_r);
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign regWrite  = reg_write_r;
  assign result    = result_r;
  assign write_reg = write_reg_r;
  assign flags     = flags_r;

endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit: directed cases plus randomized ops vs an arithmetic model.
module tb_execute_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic [3:0]  dest_reg = 4'd0;
  logic [15:0] operand_a = 16'd0;
  logic [15:0] operand_b = 16'd0;
  logic        busy, done, regWrite;
  logic [15:0] result;
  logic [3:0]  write_reg, flags;

  execute_unit #(.WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode),
    .dest_reg(dest_reg), .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result), .write_reg(write_reg),
    .regWrite(regWrite), .flags(flags)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  nzcv;
    logic [3:0]  wreg;
    logic        we;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_count = 0;
  logic [3:0]  model_flags = 4'b0000;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode's definition.
  task automatic predict(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output logic [3:0] fl);
    longint ua, ub, sa, sb, r, s;
    logic c, v;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    c = model_flags[1]; v = model_flags[0];
    r = 0;
    case (op)
      3'd0: begin r = ua + ub; c = (r > 65535); v = ((sa + sb) > 32767) || ((sa + sb) < -32768); end
      3'd1, 3'd7: begin r = ua - ub; c = (ua >= ub); v = ((sa - sb) > 32767) || ((sa - sb) < -32768); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin s = ub % 16; r = ua << s; if (s != 0) c = ((r >> 16) & 1) != 0; end
      default: r = ua * ub;
    endcase
    res = 16'(r & 65535);
    fl  = {res[15], (res == 16'd0), c, v};
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!busy && sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d, required idle within 60 cycles", busy, sbq.size());
      sbq.delete();
    end
  endtask

  // Waits for idle, pushes the prediction and pulses start; returns at the negedge after E0.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] d);
    exp_t e;
    wait_idle();
    predict(op, a, b, e.res, e.nzcv);
    model_flags = e.nzcv;
    e.wreg = d;
    e.we   = (op != 3'd7);
    e.due  = cyc + ((op == 3'd6) ? 17 : 1);
    sbq.push_back(e);
    opcode = op; operand_a = a; operand_b = b; dest_reg = d;
    start = 1'b1;
    @(negedge clock);
    start     = 1'b0;
    opcode    = 3'($urandom_range(0, 7));
    operand_a = 16'($urandom);
    operand_b = 16'($urandom);
    dest_reg  = 4'($urandom_range(0, 15));
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (done) begin
        done_count++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: done=1 result=%0h, required no completion", result);
        end else begin
          e = sbq.pop_front();
          check("result", 32'(result), 32'(e.res));
          check("flags", 32'(flags), 32'(e.nzcv));
          check("write_reg", 32'(write_reg), 32'(e.wreg));
          check("regWrite", 32'(regWrite), 32'(e.we));
          check("latency", 32'(cyc), 32'(e.due));
        end
      end else begin
        check("regWrite_without_done", 32'(regWrite), 32'd0);
      end
    end
  end

  initial begin
    logic [15:0] a, b;
    logic [2:0]  op;
    int          dc;

    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_write_reg", 32'(write_reg), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    issue(3'd0, 16'h7FFF, 16'h0001, 4'd3);
    check("add_result", 32'(result), 32'h8000);
    check("add_flags", 32'(flags), 32'b1001);
    check("add_regwrite", 32'(regWrite), 32'd1);
    @(negedge clock);
    check("add_done_one_cycle", 32'(done), 32'd0);

    issue(3'd1, 16'h0005, 16'h0005, 4'd4);
    check("sub_flags", 32'(flags), 32'b0110);
    issue(3'd7, 16'h0003, 16'h0007, 4'd5);
    check("cmp_flags", 32'(flags), 32'b1000);
    check("cmp_regwrite", 32'(regWrite), 32'd0);
    wait_idle();
    check("cmp_result_hold", 32'(result), 32'hFFFC);

    issue(3'd5, 16'h8001, 16'h0001, 4'd6);
    check("lsl1_result", 32'(result), 32'h0002);
    check("lsl1_c", 32'(flags[1]), 32'd1);
    issue(3'd5, 16'h8001, 16'h0000, 4'd6);
    check("lsl0_result", 32'(result), 32'h8001);
    check("lsl0_c", 32'(flags[1]), 32'd1);

    // MUL with an ADD start pulse mid-sequence that must be ignored.
    wait_idle();
    dc = done_count;
    issue(3'd6, 16'h0123, 16'h0010, 4'd7);
    check("mul_busy", 32'(busy), 32'd1);
    for (int i = 2; i <= 17; i++) begin
      @(negedge clock);
      check("mul_busy", 32'(busy), 32'd1);
      if (i == 4) begin
        start = 1'b1; opcode = 3'd0; operand_a = 16'h0001; operand_b = 16'h0001;
      end else begin
        start = 1'b0;
      end
    end
    check("mul_result", 32'(result), 32'h1230);
    wait_idle();
    check("mul_single_done", 32'(done_count - dc), 32'd1);

    // Reset during MUL aborts with no writeback.
    issue(3'd6, 16'h00FF, 16'h0101, 4'd9);
    repeat (6) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_flags", 32'(flags), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_regwrite", 32'(regWrite), 32'd0);
    sbq.delete();
    model_flags = 4'b0000;
    dc = done_count;
    @(negedge clock);
    reset = 1'b0;
    repeat (25) @(negedge clock);
    check("abort_no_done", 32'(done_count - dc), 32'd0);
    issue(3'd0, 16'h1234, 16'h1111, 4'd2);
    check("post_abort_add", 32'(result), 32'h2345);

    for (int n = 0; n < 80; n++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: a = 16'hFFFF;
        1: a = 16'h8000;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: b = 16'($urandom_range(0, 15));
        1: b = 16'h7FFF;
        default: b = 16'($urandom);
      endcase
      issue(op, a, b, 4'($urandom_range(0, 15)));
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
